// File: rtl/riscv_memory_if.sv
// rtl/riscv_memory_if.sv - data-memory bus between the M stage (master) and the data memory (slave)
interface riscv_memory_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            wr;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ready;
    logic [XLEN-1:0] rdata;

    modport master (output req, wr, addr, be, wdata, input ready, rdata);
    modport slave  (input req, wr, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/riscv_memory.sv
// rtl/riscv_memory.sv - RV32I memory stage: E/M register, data-memory handshake, load/store lane alignment
module riscv_memory #(
    parameter int XLEN      = 32,
    parameter int P_TIMEOUT = 16,
    parameter int P_CNT_W   = 5
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_ctrl_reg_wr_enE,
    input  logic            i_ctrl_result_srcE,
    input  logic [1:0]      i_ctrl_mux_selE,
    input  logic            i_ctrl_mem_wr_enE,
    input  logic [3:0]      i_ctrl_mem_byte_selE,
    input  logic [2:0]      i_ctrl_funct3E,
    input  logic [4:0]      i_regfile_rd_addrE,
    input  logic [XLEN-1:0] i_alu_resultE,
    input  logic [XLEN-1:0] i_mem_writedataE,
    input  logic [XLEN-1:0] i_ExtImmE,
    input  logic [XLEN-1:0] i_PCPlus4E,
    riscv_memory_if.master  dmem,
    output logic            o_ctrl_reg_wr_enM,
    output logic            o_ctrl_result_srcM,
    output logic [1:0]      o_ctrl_mux_selM,
    output logic [4:0]      o_regfile_rd_addrM,
    output logic [XLEN-1:0] o_alu_resultM,
    output logic [XLEN-1:0] o_mem_rdataM,
    output logic [XLEN-1:0] o_ExtImmM,
    output logic [XLEN-1:0] o_PCPlus4M,
    output logic            o_stallM,
    output logic            o_misalignM,
    output logic            o_dmem_errM
);
    typedef enum logic {S_IDLE, S_WAIT} memState_t;
    memState_t state, nextState;

    logic               regWrEnM, resultSrcM, memWrEnM, unsignedM;
    logic [1:0]         muxSelM;
    logic [3:0]         byteSelM;
    logic [4:0]         rdAddrM;
    logic [XLEN-1:0]    aluResultM, writeDataM, extImmM, pcPlus4M;
    logic [P_CNT_W-1:0] waitCnt;
    logic [1:0]         offs;
    logic               stall, timeout, advance, req;
    logic               memopM, misalignM, accessE;
    logic [XLEN-1:0]    shifted;
    logic               signBit;
    logic               unusedBits;

    function automatic logic misaligned(input logic [3:0] sel, input logic [1:0] lowAddr);
        return (sel == 4'b0011 && lowAddr[0]) || (sel == 4'b1111 && lowAddr != 2'b00);
    endfunction

    assign unusedBits = ^i_ctrl_funct3E[1:0];
    assign offs       = aluResultM[1:0];
    assign memopM     = resultSrcM | memWrEnM;
    assign misalignM  = memopM && misaligned(byteSelM, offs);
    // WAIT means the instruction now sitting in M is an aligned access, so the
    // decision is taken from the E bundle at the edge that captures it.
    assign accessE    = (i_ctrl_result_srcE | i_ctrl_mem_wr_enE)
                        && !misaligned(i_ctrl_mem_byte_selE, i_alu_resultE[1:0]);
    assign advance    = !stall;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            regWrEnM   <= 1'b0;
            resultSrcM <= 1'b0;
            muxSelM    <= 2'b00;
            memWrEnM   <= 1'b0;
            byteSelM   <= 4'b0000;
            unsignedM  <= 1'b0;
            rdAddrM    <= 5'd0;
            aluResultM <= '0;
            writeDataM <= '0;
            extImmM    <= '0;
            pcPlus4M   <= '0;
        end else if (advance) begin
            regWrEnM   <= i_ctrl_reg_wr_enE;
            resultSrcM <= i_ctrl_result_srcE;
            muxSelM    <= i_ctrl_mux_selE;
            memWrEnM   <= i_ctrl_mem_wr_enE;
            byteSelM   <= i_ctrl_mem_byte_selE;
            unsignedM  <= i_ctrl_funct3E[2];
            rdAddrM    <= i_regfile_rd_addrE;
            aluResultM <= i_alu_resultE;
            writeDataM <= i_mem_writedataE;
            extImmM    <= i_ExtImmE;
            pcPlus4M   <= i_PCPlus4E;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= S_IDLE;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= advance ? '0 : waitCnt + P_CNT_W'(1);
        end
    end

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        timeout   = 1'b0;
        if (state == S_WAIT && !dmem.ready) begin
            if (waitCnt == P_CNT_W'(P_TIMEOUT - 1)) timeout = 1'b1;
            else                                    stall   = 1'b1;
        end
        if (!stall) nextState = accessE ? S_WAIT : S_IDLE;
    end

    assign req         = (state == S_WAIT);
    assign dmem.req    = req;
    assign dmem.wr     = req & memWrEnM;
    assign dmem.addr   = req ? {aluResultM[XLEN-1:2], 2'b00} : '0;
    assign dmem.be     = req ? (byteSelM << offs) : 4'b0000;
    assign dmem.wdata  = req ? (writeDataM << {offs, 3'b000}) : '0;

    always_comb begin
        shifted      = dmem.rdata >> {offs, 3'b000};
        signBit      = 1'b0;
        o_mem_rdataM = '0;
        if (resultSrcM && !timeout) begin
            if (byteSelM == 4'b0001) begin
                signBit      = !unsignedM && shifted[7];
                o_mem_rdataM = {{(XLEN-8){signBit}}, shifted[7:0]};
            end else if (byteSelM == 4'b0011) begin
                signBit      = !unsignedM && shifted[15];
                o_mem_rdataM = {{(XLEN-16){signBit}}, shifted[15:0]};
            end else begin
                o_mem_rdataM = shifted;
            end
        end
    end

    assign o_ctrl_reg_wr_enM  = regWrEnM && !misalignM;
    assign o_ctrl_result_srcM = resultSrcM;
    assign o_ctrl_mux_selM    = muxSelM;
    assign o_regfile_rd_addrM = rdAddrM;
    assign o_alu_resultM      = aluResultM;
    assign o_ExtImmM          = extImmM;
    assign o_PCPlus4M         = pcPlus4M;
    assign o_stallM           = stall;
    assign o_misalignM        = misalignM;
    assign o_dmem_errM        = timeout;
endmodule

// File: tb/tb_riscv_memory.sv
// tb/tb_riscv_memory.sv - bench for riscv_memory: instruction-level model plus literal expectations
module tb_riscv_memory;
    localparam int XLEN = 32;
    localparam int N    = 13;

    logic            i_clk = 1'b0;
    logic            i_rstn = 1'b0;
    logic            i_ctrl_reg_wr_enE, i_ctrl_result_srcE, i_ctrl_mem_wr_enE;
    logic [1:0]      i_ctrl_mux_selE;
    logic [3:0]      i_ctrl_mem_byte_selE;
    logic [2:0]      i_ctrl_funct3E;
    logic [4:0]      i_regfile_rd_addrE;
    logic [XLEN-1:0] i_alu_resultE, i_mem_writedataE, i_ExtImmE, i_PCPlus4E;
    logic            o_ctrl_reg_wr_enM, o_ctrl_result_srcM, o_stallM, o_misalignM, o_dmem_errM;
    logic [1:0]      o_ctrl_mux_selM;
    logic [4:0]      o_regfile_rd_addrM;
    logic [XLEN-1:0] o_alu_resultM, o_mem_rdataM, o_ExtImmM, o_PCPlus4M;

    riscv_memory_if #(.XLEN(XLEN)) dmem ();

    riscv_memory #(.XLEN(XLEN), .P_TIMEOUT(16), .P_CNT_W(5)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_ctrl_reg_wr_enE(i_ctrl_reg_wr_enE), .i_ctrl_result_srcE(i_ctrl_result_srcE),
        .i_ctrl_mux_selE(i_ctrl_mux_selE), .i_ctrl_mem_wr_enE(i_ctrl_mem_wr_enE),
        .i_ctrl_mem_byte_selE(i_ctrl_mem_byte_selE), .i_ctrl_funct3E(i_ctrl_funct3E),
        .i_regfile_rd_addrE(i_regfile_rd_addrE), .i_alu_resultE(i_alu_resultE),
        .i_mem_writedataE(i_mem_writedataE), .i_ExtImmE(i_ExtImmE), .i_PCPlus4E(i_PCPlus4E),
        .dmem(dmem),
        .o_ctrl_reg_wr_enM(o_ctrl_reg_wr_enM), .o_ctrl_result_srcM(o_ctrl_result_srcM),
        .o_ctrl_mux_selM(o_ctrl_mux_selM), .o_regfile_rd_addrM(o_regfile_rd_addrM),
        .o_alu_resultM(o_alu_resultM), .o_mem_rdataM(o_mem_rdataM), .o_ExtImmM(o_ExtImmM),
        .o_PCPlus4M(o_PCPlus4M), .o_stallM(o_stallM), .o_misalignM(o_misalignM),
        .o_dmem_errM(o_dmem_errM)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ld, st, rw;
        logic [3:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  dst;
        logic [31:0] addr, wdata, rdata;
        int          rdy;       // cycles before ready; -1 = never
        logic [31:0] litData;   // load result or lane-aligned store data at completion
        logic [3:0]  litBe;
        int          litStalls;
    } ins_t;

    ins_t tbl [N];
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic ld, input logic st, input logic rw, input logic [3:0] sel,
                                input logic [2:0] f3, input logic [4:0] dst, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int rdy,
                                input logic [31:0] litData, input logic [3:0] litBe, input int litStalls);
        ins_t x;
        x.ld = ld; x.st = st; x.rw = rw; x.sel = sel; x.f3 = f3; x.dst = dst;
        x.addr = addr; x.wdata = wdata; x.rdata = rdata; x.rdy = rdy;
        x.litData = litData; x.litBe = litBe; x.litStalls = litStalls;
        return x;
    endfunction

    function automatic int sizeOf(input logic [3:0] sel);
        return (sel == 4'b0001) ? 1 : (sel == 4'b0011) ? 2 : 4;
    endfunction

    function automatic logic [31:0] extOf(input int idx);
        return (idx >= 0) ? 32'h0000_0100 + idx : 32'h0;
    endfunction

    function automatic logic [31:0] pcOf(input int idx);
        return (idx >= 0) ? 32'h0000_1000 + 4 * idx : 32'h0;
    endfunction

    function automatic logic [31:0] loadVal(input ins_t m, input logic [31:0] rd, input logic to);
        int          sz;
        logic [31:0] s, mask;
        if (!m.ld || to) return 32'h0;
        sz = sizeOf(m.sel);
        s  = rd >> (8 * m.addr[1:0]);
        if (sz == 4) return s;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        s    = s & mask;
        if (!m.f3[2] && s[8*sz-1]) s = s | ~mask;
        return s;
    endfunction

    task automatic driveE(input ins_t x, input int idx);
        i_ctrl_reg_wr_enE    = x.rw;
        i_ctrl_result_srcE   = x.ld;
        i_ctrl_mux_selE      = x.dst[1:0];
        i_ctrl_mem_wr_enE    = x.st;
        i_ctrl_mem_byte_selE = x.sel;
        i_ctrl_funct3E       = x.f3;
        i_regfile_rd_addrE   = x.dst;
        i_alu_resultE        = x.addr;
        i_mem_writedataE     = x.wdata;
        i_ExtImmE            = extOf(idx);
        i_PCPlus4E           = pcOf(idx);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_req"},    dmem.req, 0);
        chk({tag, "_wr"},     dmem.wr, 0);
        chk({tag, "_addr"},   dmem.addr, 0);
        chk({tag, "_be"},     dmem.be, 0);
        chk({tag, "_wdata"},  dmem.wdata, 0);
        chk({tag, "_stall"},  o_stallM, 0);
        chk({tag, "_err"},    o_dmem_errM, 0);
        chk({tag, "_regwr"},  o_ctrl_reg_wr_enM, 0);
        chk({tag, "_alu"},    o_alu_resultM, 0);
        chk({tag, "_rdata"},  o_mem_rdataM, 0);
        chk({tag, "_rdaddr"}, o_regfile_rd_addrM, 0);
        chk({tag, "_pc"},     o_PCPlus4M, 0);
    endtask

    initial begin
        ins_t        bub, eIns, mIns, lwT;
        int          eIdx, mIdx, waited, stallSeen, errSeen, sz, cyc;
        logic [1:0]  offs;
        logic        memop, mis, active, readyNow, to, expStall;
        logic [31:0] rd;

        //              ld st rw sel      f3      dst addr          wdata         rdata         rdy lit           be       stalls
        tbl[0]  = mk(0, 1, 0, 4'b1111, 3'b010, 0,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0,  32'hDEAD_BEEF, 4'b1111, 0);
        tbl[1]  = mk(1, 0, 1, 4'b0001, 3'b000, 5,  32'h0000_0203, 32'h0,         32'h8011_2233, 0,  32'hFFFF_FF80, 4'b1000, 0);
        tbl[2]  = mk(1, 0, 1, 4'b0001, 3'b100, 6,  32'h0000_0203, 32'h0,         32'h8011_2233, 0,  32'h0000_0080, 4'b1000, 0);
        tbl[3]  = mk(0, 1, 0, 4'b0011, 3'b001, 0,  32'h0000_0302, 32'h0000_ABCD, 32'h0,         3,  32'hABCD_0000, 4'b1100, 3);
        tbl[4]  = mk(1, 0, 1, 4'b1111, 3'b010, 8,  32'h0000_0500, 32'h0,         32'h1111_1111, -1, 32'h0,         4'b1111, 15);
        tbl[5]  = mk(1, 0, 1, 4'b1111, 3'b010, 9,  32'h0000_0401, 32'h0,         32'h0,         0,  32'h0,         4'b0000, 0);
        tbl[6]  = mk(0, 0, 1, 4'b0000, 3'b000, 7,  32'h1234_5679, 32'h0,         32'h0,         0,  32'h0,         4'b0000, 0);
        tbl[7]  = mk(1, 0, 1, 4'b0011, 3'b001, 10, 32'h0000_0602, 32'h0,         32'h8001_7FFF, 1,  32'hFFFF_8001, 4'b1100, 1);
        tbl[8]  = mk(1, 0, 1, 4'b0011, 3'b101, 11, 32'h0000_0600, 32'h0,         32'h1234_F00D, 0,  32'h0000_F00D, 4'b0011, 0);
        tbl[9]  = mk(0, 1, 0, 4'b0001, 3'b000, 0,  32'h0000_0703, 32'h0000_00A5, 32'h0,         0,  32'hA500_0000, 4'b1000, 0);
        tbl[10] = mk(0, 1, 0, 4'b0011, 3'b001, 0,  32'h0000_0301, 32'h0000_1234, 32'h0,         0,  32'h0,         4'b0000, 0);
        tbl[11] = mk(1, 0, 1, 4'b1111, 3'b010, 12, 32'h0000_0800, 32'h0,         32'hCAFE_F00D, 2,  32'hCAFE_F00D, 4'b1111, 2);
        tbl[12] = mk(0, 1, 0, 4'b1111, 3'b010, 0,  32'h0000_0804, 32'h0102_0304, 32'h0,         0,  32'h0102_0304, 4'b1111, 0);

        bub = mk(0, 0, 0, 4'b0000, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 4'b0000, 0);
        driveE(tbl[0], 0);
        dmem.ready = 1'b1;
        dmem.rdata = 32'hFFFF_FFFF;
        #12;
        chkAllZero("reset");
        driveE(bub, -1);
        @(negedge i_clk);
        i_rstn = 1'b1;

        mIns = bub; mIdx = -1; eIdx = 0; waited = 0; stallSeen = 0; errSeen = 0; cyc = 0;
        while (cyc < 300 && !(eIdx >= N && mIdx < 0)) begin
            @(negedge i_clk);
            eIns = (eIdx < N) ? tbl[eIdx] : bub;
            driveE(eIns, (eIdx < N) ? eIdx : -1);
            sz       = sizeOf(mIns.sel);
            offs     = mIns.addr[1:0];
            memop    = mIns.ld | mIns.st;
            mis      = memop && ((mIns.addr % sz) != 0);
            active   = memop && !mis;
            readyNow = active ? (mIns.rdy >= 0 && waited == mIns.rdy) : cyc[0];
            rd       = memop ? mIns.rdata : $urandom();
            dmem.ready = readyNow;
            dmem.rdata = rd;
            to       = active && !readyNow && waited == 15;
            expStall = active && !readyNow && !to;
            #1;
            chk("req",       dmem.req, active);
            chk("wr",        dmem.wr, active & mIns.st);
            chk("addr",      dmem.addr, active ? {mIns.addr[31:2], 2'b00} : 32'h0);
            chk("be",        dmem.be, active ? 4'(((1 << sz) - 1) << offs) : 4'h0);
            chk("wdata",     dmem.wdata, active ? (mIns.wdata << (8 * offs)) : 32'h0);
            chk("stall",     o_stallM, expStall);
            chk("err",       o_dmem_errM, to);
            chk("misalign",  o_misalignM, mis);
            chk("regwr",     o_ctrl_reg_wr_enM, mIns.rw && !mis);
            chk("resultsrc", o_ctrl_result_srcM, mIns.ld);
            chk("muxsel",    o_ctrl_mux_selM, mIns.dst[1:0]);
            chk("rdaddr",    o_regfile_rd_addrM, mIns.dst);
            chk("aluresult", o_alu_resultM, mIns.addr);
            chk("extimm",    o_ExtImmM, extOf(mIdx));
            chk("pcplus4",   o_PCPlus4M, pcOf(mIdx));
            chk("memrdata",  o_mem_rdataM, loadVal(mIns, rd, to));
            if (o_stallM) stallSeen++;
            if (o_dmem_errM) errSeen++;
            if (mIdx >= 0 && waited == 0)
                chk($sformatf("lit_be[%0d]", mIdx), dmem.be, mIns.litBe);
            if (!expStall) begin
                if (mIdx >= 0) begin
                    chk($sformatf("lit_data[%0d]", mIdx), mIns.ld ? o_mem_rdataM : dmem.wdata, mIns.litData);
                    chk($sformatf("lit_stalls[%0d]", mIdx), stallSeen, mIns.litStalls);
                end
                mIns = eIns;
                mIdx = (eIdx < N) ? eIdx : -1;
                if (eIdx < N) eIdx++;
                waited    = 0;
                stallSeen = 0;
            end else begin
                waited++;
            end
            cyc++;
        end
        chk("progress", (eIdx >= N && mIdx < 0), 1);
        chk("err_pulses", errSeen, 1);

        lwT = mk(1, 0, 1, 4'b1111, 3'b010, 13, 32'h0000_0900, 32'h0, 32'h0, -1, 32'h0, 4'b1111, 0);
        @(negedge i_clk);
        driveE(lwT, 20);
        dmem.ready = 1'b0;
        @(negedge i_clk);
        #1;
        chk("rst_pre_req",   dmem.req, 1);
        chk("rst_pre_stall", o_stallM, 1);
        @(negedge i_clk);
        driveE(bub, -1);
        #2 i_rstn = 1'b0;
        #1;
        chkAllZero("rst_mid");
        @(negedge i_clk);
        dmem.ready = 1'b1;
        i_rstn = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        chkAllZero("rst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
